data_memory_be: RTL and testbench

Parametrised, byte-addressable data memory for the single-cycle/multi-cycle MIPS datapath. It supports byte, halfword and word loads and stores with sign or zero extension, byte-lane write masking and a configurable number of wait states behind a request/ready handshake. It sits between the ALU address output and the write-back mux, and replaces the word-only combinational-read memory.

---
 rtl/data_memory_be_if.sv | 38 +++
 rtl/data_memory_be.sv | 243 ++++++++++++++++++++++++
 tb/tb_data_memory_be.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/data_memory_be_if.sv
// data_memory_be_if
//   Request/response bundle between a datapath master and data_memory_be.
//   master drives the request fields (i_*) and observes the response (o_*);
//   slave is the memory side.
//   i_req      access request, level-sensitive
//   i_we       1 = store, 0 = load
//   i_size     00 byte, 01 half, 10/11 word
//   i_unsigned load extension: 1 = zero, 0 = sign
//   i_addr     byte address
//   i_wdata    store data, right-justified for byte/half
//   o_rdata    load result, valid with o_ready
//   o_ready    one-cycle completion pulse
//   o_busy     access in flight
//   o_err      misalignment flag, qualified by o_ready
interface data_memory_be_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  i_req;
  logic                  i_we;
  logic [1:0]            i_size;
  logic                  i_unsigned;
  logic [31:0]           i_addr;
  logic [DATA_WIDTH-1:0] i_wdata;
  logic [DATA_WIDTH-1:0] o_rdata;
  logic                  o_ready;
  logic                  o_busy;
  logic                  o_err;

  modport master (
    output i_req, i_we, i_size, i_unsigned, i_addr, i_wdata,
    input  o_rdata, o_ready, o_busy, o_err
  );

  modport slave (
    input  i_req, i_we, i_size, i_unsigned, i_addr, i_wdata,
    output o_rdata, o_ready, o_busy, o_err
  );
endinterface

// File: rtl/data_memory_be.sv
// data_memory_be
//   Byte-addressable data memory with byte/half/word loads and stores,
//   sign/zero extension, byte-lane write masking and WAIT_STATES extra
//   cycles per access behind a request/ready handshake.
//   Ports:
//     i_clk  clock, rising edge
//     i_rst  synchronous active-high reset
//     bus    data_memory_be_if.slave (request fields in, response out)
//   Parameters:
//     DATA_WIDTH  data path width (32 only)
//     ADDR_WIDTH  word-address bits, depth 2**ADDR_WIDTH words
//     WAIT_STATES extra cycles per access, 0..7
//   Build option:
//     DMEM_ALIGN_CHECK_EN  misaligned accesses are rejected (no write,
//     rdata 0, o_err 1). Undefined: low address bits are forced to
//     alignment and o_err is tied low.
//   Memory contents are not cleared by reset.
module data_memory_be #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 7,
  parameter int unsigned WAIT_STATES = 1
) (
  input logic              i_clk,
  input logic              i_rst,
  data_memory_be_if.slave  bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [2:0]              cnt_q, cnt_d;
  logic                    access;
  logic                    busy;
  logic                    ready;

  // Latched request fields
  logic [31:0]             addr_q;
  logic [1:0]              size_q;
  logic                    we_q;
  logic                    uns_q;
  logic [DATA_WIDTH-1:0]   wdata_q;

  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  // Fields used by the access: with zero wait states the access happens on
  // the accept edge itself, so IDLE takes them straight from the bus.
  logic [31:0]             a_addr;
  logic [1:0]              a_size;
  logic                    a_we;
  logic                    a_uns;
  logic [DATA_WIDTH-1:0]   a_wdata;
  logic [ADDR_WIDTH-1:0]   a_idx;
  logic [1:0]              off;
  logic [3:0]              be;
  logic [DATA_WIDTH-1:0]   lane_data;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic [7:0]              rd_byte;
  logic [15:0]             rd_half;
  logic [DATA_WIDTH-1:0]   load_val;
  logic                    wr_en;
  logic [DATA_WIDTH-1:0]   rdata_next;
  logic                    err_next;
  logic                    unused_addr_hi;

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    access  = 1'b0;
    busy    = 1'b1;
    ready   = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (bus.i_req) begin
          if (WAIT_STATES == 0) begin
            access  = 1'b1;
            state_d = DONE;
          end else begin
            cnt_d   = 3'(WAIT_STATES);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          access  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        ready   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Request capture and access decode
  // ---------------------------------------------------------------------
  always_comb begin
    if (state_q == IDLE) begin
      a_addr  = bus.i_addr;
      a_size  = bus.i_size;
      a_we    = bus.i_we;
      a_uns   = bus.i_unsigned;
      a_wdata = bus.i_wdata;
    end else begin
      a_addr  = addr_q;
      a_size  = size_q;
      a_we    = we_q;
      a_uns   = uns_q;
      a_wdata = wdata_q;
    end
  end

  // Upper address bits are ignored so the address wraps.
  assign a_idx          = a_addr[ADDR_WIDTH+1:2];
  assign unused_addr_hi = ^a_addr[31:ADDR_WIDTH+2];

`ifdef DMEM_ALIGN_CHECK_EN
  logic misaligned;
  assign misaligned = ((a_size == 2'b01) && a_addr[0]) ||
                      (a_size[1] && (a_addr[1:0] != 2'b00));
`endif

  always_comb begin
    off = a_addr[1:0];
`ifndef DMEM_ALIGN_CHECK_EN
    if (a_size == 2'b01) off[0] = 1'b0;
    if (a_size[1])       off    = 2'b00;
`endif
    be        = 4'b1111;
    lane_data = a_wdata;
    unique case (a_size)
      2'b00: begin
        be        = 4'b0001 << off;
        lane_data = {4{a_wdata[7:0]}};
      end
      2'b01: begin
        be        = off[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{a_wdata[15:0]}};
      end
      default: begin
        be        = 4'b1111;
        lane_data = a_wdata;
      end
    endcase
  end

  always_comb begin
    rd_word = mem[a_idx];
    rd_byte = rd_word[8*off +: 8];
    rd_half = rd_word[16*off[1] +: 16];
    unique case (a_size)
      2'b00:   load_val = a_uns ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      2'b01:   load_val = a_uns ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
      default: load_val = rd_word;
    endcase
  end

  always_comb begin
`ifdef DMEM_ALIGN_CHECK_EN
    wr_en      = access && a_we && !misaligned;
    rdata_next = (a_we || misaligned) ? '0 : load_val;
    err_next   = misaligned;
`else
    wr_en      = access && a_we;
    rdata_next = a_we ? '0 : load_val;
    err_next   = 1'b0;
`endif
  end

  // ---------------------------------------------------------------------
  // Storage and registered response
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_rst && wr_en) begin
      for (int unsigned n = 0; n < 4; n++) begin
        if (be[n]) mem[a_idx][8*n +: 8] <= lane_data[8*n +: 8];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      addr_q  <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (state_q == IDLE && bus.i_req) begin
        addr_q  <= bus.i_addr;
        size_q  <= bus.i_size;
        we_q    <= bus.i_we;
        uns_q   <= bus.i_unsigned;
        wdata_q <= bus.i_wdata;
      end
      if (access) rdata_q <= rdata_next;
    end
  end

`ifdef DMEM_ALIGN_CHECK_EN
  logic err_q;
  always_ff @(posedge i_clk) begin
    if (i_rst)       err_q <= 1'b0;
    else if (access) err_q <= err_next;
  end
  assign bus.o_err = err_q;
`else
  logic unused_err;
  assign unused_err = err_next;
  assign bus.o_err  = 1'b0;
`endif

  assign bus.o_rdata = rdata_q;
  assign bus.o_ready = ready;
  assign bus.o_busy  = busy;

endmodule

// File: tb/tb_data_memory_be.sv
module tb_data_memory_be;

  logic clk = 1'b0;
  logic rst;
  int   n_total = 0;
  int   n_bad   = 0;

  always #5 clk = ~clk;

  data_memory_be_if #(.DATA_WIDTH(32)) bus1 ();
  data_memory_be_if #(.DATA_WIDTH(32)) bus0 ();

  data_memory_be #(.DATA_WIDTH(32), .ADDR_WIDTH(7), .WAIT_STATES(1)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus1)
  );

  data_memory_be #(.DATA_WIDTH(32), .ADDR_WIDTH(7), .WAIT_STATES(0)) dut0 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One access on the WAIT_STATES=1 instance; request fields are scrambled
  // after the accept edge to show they were latched.
  task automatic dmem_access(input logic we, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             output logic [31:0] rdata, output logic err, output int lat);
    bus1.i_we       = we;
    bus1.i_size     = size;
    bus1.i_unsigned = uns;
    bus1.i_addr     = addr;
    bus1.i_wdata    = wdata;
    bus1.i_req      = 1'b1;
    @(posedge clk); #1;
    bus1.i_req      = 1'b0;
    bus1.i_we       = ~we;
    bus1.i_size     = ~size;
    bus1.i_unsigned = ~uns;
    bus1.i_addr     = 32'h0000_007C;
    bus1.i_wdata    = 32'h5555_5555;
    lat = 1;
    while (!bus1.o_ready && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!bus1.o_ready) lat = 99;
    rdata = bus1.o_rdata;
    err   = bus1.o_err;
    @(posedge clk); #1;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  int          pulses;

  initial begin
    rst = 1'b1;
    bus1.i_req = 1'b0; bus1.i_we = 1'b0; bus1.i_size = 2'b10; bus1.i_unsigned = 1'b0;
    bus1.i_addr = '0;  bus1.i_wdata = '0;
    bus0.i_req = 1'b0; bus0.i_we = 1'b0; bus0.i_size = 2'b10; bus0.i_unsigned = 1'b0;
    bus0.i_addr = '0;  bus0.i_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(bus1.o_ready), 32'd0);
    check("rst_busy",  32'(bus1.o_busy),  32'd0);
    check("rst_rdata", bus1.o_rdata,      32'h0);
    check("rst_err",   32'(bus1.o_err),   32'd0);

    // Request together with reset is not accepted
    bus1.i_req = 1'b1;
    @(posedge clk); #1;
    bus1.i_req = 1'b0;
    rst = 1'b0;
    check("req_in_rst_busy", 32'(bus1.o_busy), 32'd0);
    @(posedge clk); #1;
    check("req_in_rst_ready", 32'(bus1.o_ready), 32'd0);

    // Word store / load with latency
    dmem_access(1'b1, 2'b10, 1'b0, 32'h10, 32'h8899_AABB, rd, er, lat);
    check("st_w_lat",   32'(lat), 32'd2);
    check("st_w_rdata", rd, 32'h0);
    dmem_access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat);
    check("ld_w_lat", 32'(lat), 32'd2);
    check("ld_w",     rd, 32'h8899_AABB);

    // Byte store and byte loads
    dmem_access(1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFF_FF7F, rd, er, lat);
    dmem_access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat);
    check("ld_w_after_sb", rd, 32'h8899_7FBB);
    dmem_access(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, rd, er, lat);
    check("lb_s", rd, 32'hFFFF_FF88);
    dmem_access(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, rd, er, lat);
    check("lb_u", rd, 32'h0000_0088);
    dmem_access(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, rd, er, lat);
    check("lb_s_pos", rd, 32'h0000_007F);

    // Half stores and loads
    dmem_access(1'b1, 2'b01, 1'b0, 32'h22, 32'hABCD_1234, rd, er, lat);
    dmem_access(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, rd, er, lat);
    check("lh_s_22", rd, 32'h0000_1234);
    dmem_access(1'b1, 2'b01, 1'b0, 32'h20, 32'h0000_8001, rd, er, lat);
    dmem_access(1'b0, 2'b01, 1'b0, 32'h20, 32'h0, rd, er, lat);
    check("lh_s_20", rd, 32'hFFFF_8001);
    dmem_access(1'b0, 2'b01, 1'b1, 32'h20, 32'h0, rd, er, lat);
    check("lh_u_20", rd, 32'h0000_8001);
    dmem_access(1'b0, 2'b11, 1'b0, 32'h20, 32'h0, rd, er, lat);
    check("ld_w_20_sz11", rd, 32'h1234_8001);

    // Wrap and misalignment
    dmem_access(1'b1, 2'b10, 1'b0, 32'h0, 32'hCAFE_F00D, rd, er, lat);
    dmem_access(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, rd, er, lat);
    check("ld_wrap",     rd, 32'hCAFE_F00D);
    check("ld_wrap_err", 32'(er), 32'd0);
    dmem_access(1'b0, 2'b10, 1'b0, 32'h203, 32'h0, rd, er, lat);
`ifdef DMEM_ALIGN_CHECK_EN
    check("ld_mis_w",     rd, 32'h0);
    check("ld_mis_w_err", 32'(er), 32'd1);
`else
    check("ld_mis_w",     rd, 32'hCAFE_F00D);
    check("ld_mis_w_err", 32'(er), 32'd0);
`endif
    dmem_access(1'b1, 2'b10, 1'b0, 32'h201, 32'h1111_1111, rd, er, lat);
    dmem_access(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, rd, er, lat);
`ifdef DMEM_ALIGN_CHECK_EN
    check("st_mis_w_blocked", rd, 32'hCAFE_F00D);
`else
    check("st_mis_w_aligned", rd, 32'h1111_1111);
`endif
    check("ld_ok_err_clear", 32'(er), 32'd0);
    dmem_access(1'b0, 2'b01, 1'b1, 32'h23, 32'h0, rd, er, lat);
`ifdef DMEM_ALIGN_CHECK_EN
    check("lh_mis",     rd, 32'h0);
    check("lh_mis_err", 32'(er), 32'd1);
`else
    check("lh_mis",     rd, 32'h0000_1234);
    check("lh_mis_err", 32'(er), 32'd0);
`endif

    // Reset during WAIT drops the store
    dmem_access(1'b1, 2'b10, 1'b0, 32'h40, 32'h0102_0304, rd, er, lat);
    bus1.i_we = 1'b1; bus1.i_size = 2'b10; bus1.i_addr = 32'h40;
    bus1.i_wdata = 32'hDEAD_BEEF; bus1.i_req = 1'b1;
    @(posedge clk); #1;
    bus1.i_req = 1'b0;
    check("wait_busy", 32'(bus1.o_busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus1.o_ready) pulses++;
      @(posedge clk); #1;
    end
    check("rst_wait_no_ready", 32'(pulses), 32'd0);
    check("rst_wait_busy", 32'(bus1.o_busy), 32'd0);
    dmem_access(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, rd, er, lat);
    check("rst_wait_no_write", rd, 32'h0102_0304);

    // WAIT_STATES=0: back-to-back stores with i_req held high
    bus0.i_we = 1'b1; bus0.i_size = 2'b10; bus0.i_addr = 32'h4;
    bus0.i_wdata = 32'h5A5A_0001; bus0.i_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check($sformatf("ws0_ready_%0d", i), 32'(bus0.o_ready), 32'((i % 2) == 0));
      check($sformatf("ws0_busy_%0d", i),  32'(bus0.o_busy),  32'((i % 2) == 0));
    end
    bus0.i_we = 1'b0;
    @(posedge clk); #1;
    bus0.i_req = 1'b0;
    check("ws0_ld_ready", 32'(bus0.o_ready), 32'd1);
    check("ws0_ld_data",  bus0.o_rdata, 32'h5A5A_0001);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
